// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-master bus arbiter with timeout fault; define ARB_ROUND_ROBIN_EN for round-robin tie-break.
module bus_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_data_o,
    input  logic [31:0] m1_data_o,
    output logic [31:0] m0_data_i,
    output logic [31:0] m1_data_i,
    input  logic        m0_rd_n,
    input  logic        m0_wr_n,
    input  logic        m1_rd_n,
    input  logic        m1_wr_n,
    input  logic [3:0]  m0_be,
    input  logic [3:0]  m1_be,
    output logic        m0_rdy,
    output logic        m1_rdy,
    output logic        m0_acc_fault,
    output logic        m1_acc_fault,
    output logic [31:0] s_addr,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    output logic        s_rd_n,
    output logic        s_wr_n,
    output logic [3:0]  s_be,
    input  logic        s_rdy,
    input  logic        s_acc_fault,
    output logic [1:0]  gnt,
    output logic        to_err
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, FAULT} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       own_q, own_d;
    logic       req0, req1, pick1, own_req, done;
    logic       g0, g1, flt;
    assign req0    = ~m0_rd_n | ~m0_wr_n;
    assign req1    = ~m1_rd_n | ~m1_wr_n;
    assign own_req = own_q ? req1 : req0;
    assign done    = s_rdy | s_acc_fault;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // last_q = 1 means m1 owned last, so m0 wins the next tie
    assign pick1 = (req0 && req1) ? ~last_q : req1;
`else
    assign pick1 = ~req0 & req1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            own_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = pick1 ? GNT1 : GNT0;
                    own_d   = pick1;
                    cnt_d   = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pick1;
`endif
                end
            end
            GNT0, GNT1: begin
                // completion and abandon both take priority over timeout
                if (done || !own_req) state_d = IDLE;
                else if (cnt_q == 8'(TIMEOUT - 1)) state_d = FAULT;
                else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign g0  = state_q == GNT0;
    assign g1  = state_q == GNT1;
    assign flt = state_q == FAULT;
    assign s_addr       = g0 ? m0_addr : g1 ? m1_addr : 32'd0;
    assign s_data_o     = g0 ? m0_data_o : g1 ? m1_data_o : 32'd0;
    assign s_be         = g0 ? m0_be : g1 ? m1_be : 4'd0;
    assign s_rd_n       = g0 ? m0_rd_n : g1 ? m1_rd_n : 1'b1;
    assign s_wr_n       = g0 ? m0_wr_n : g1 ? m1_wr_n : 1'b1;
    assign m0_data_i    = s_data_i;
    assign m1_data_i    = s_data_i;
    assign m0_rdy       = g0 & s_rdy;
    assign m1_rdy       = g1 & s_rdy;
    assign m0_acc_fault = (g0 & s_acc_fault) | (flt & ~own_q);
    assign m1_acc_fault = (g1 & s_acc_fault) | (flt & own_q);
    assign gnt          = {g1 | (flt & own_q), g0 | (flt & ~own_q)};
    assign to_err       = flt;
endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles a granted transfer may wait for slave completion; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 m0_addr, m1_addr  input  32  master address (m0 = CPU, m1 = DMA/second master).
REQ-005 m0_data_o, m1_data_o  input  32  master write data.
REQ-006 m0_data_i, m1_data_i  output  32  read data to master.
REQ-007 m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n  input  1  active-low read/write strobes.
REQ-008 m0_be, m1_be  input  4  byte lanes {h32,h24,l16,l8}, active-high.
REQ-009 m0_rdy, m1_rdy, m0_acc_fault, m1_acc_fault  output  1  completion and fault to each master.
REQ-010 s_addr, s_data_o  output  32  address and write data to the bus matrix.
REQ-011 s_data_i  input  32  read data from the bus matrix.
REQ-012 s_rd_n, s_wr_n  output  1, and s_be  output  4  strobes and byte lanes to the bus matrix.
REQ-013 s_rdy, s_acc_fault  input  1  bus matrix completion and fault.
REQ-014 gnt  output  2  one-hot current owner (bit0 = m0, bit1 = m1); to_err  output  1  one-cycle timeout pulse.

Function
REQ-015 Request rule: mX requests when mX_rd_n = 0 or mX_wr_n = 0.
REQ-016 The FSM has four registered states: IDLE, GNT0, GNT1 and FAULT.
REQ-017 IDLE behaviour: s_rd_n = s_wr_n = 1; s_be, s_addr and s_data_o = 0; gnt = 00.
REQ-018 IDLE transition: with a single requester, go to GNTx on the next edge; with no request, stay in IDLE.
REQ-019 IDLE with simultaneous requests: the winner is chosen per REQ-034/REQ-035.
REQ-020 GNTx routing: mX address, data, strobes and byte lanes pass combinationally to s_*; s_rdy goes to mX_rdy and s_acc_fault goes to mX_acc_fault.
REQ-021 GNTx, other master: the non-owner sees rdy = 0 and acc_fault = 0.
REQ-022 Read data: s_data_i is broadcast to both m0_data_i and m1_data_i in all states.
REQ-023 Completion: in GNTx, a cycle with s_rdy = 1 or s_acc_fault = 1 completes the transfer; the next state is IDLE.
REQ-024 Turnaround: the IDLE cycle after completion is mandatory, so registered slave rdy can drop; minimum grant-to-grant spacing is 1 idle cycle.
REQ-025 Latency: a request sampled in IDLE at edge N gives slave strobes active from cycle N+1.
REQ-026 Abandon: if the owner drops its request in GNTx without completion, the next state is IDLE and no fault is raised.
REQ-027 Timeout counter: the 8-bit counter clears on GNTx entry and increments each GNTx cycle without completion.
REQ-028 Timeout trigger: when the counter reaches TIMEOUT - 1 without completion, the next state is FAULT.
REQ-029 FAULT cycle: slave strobes are inactive, the owning master gets acc_fault = 1 and rdy = 0, and to_err = 1.
REQ-030 FAULT exit: the next state is IDLE; gnt keeps the faulted owner during FAULT.
REQ-031 Completion wins over timeout when both occur in the same cycle.
REQ-032 The arbiter performs no check of simultaneous rd_n = wr_n = 0; both strobes pass through.

Reset
REQ-033 On a rst edge the arbiter enters IDLE, clears the counter and sets last-owner = m1, from any state including mid-transfer; from the following cycle all s_* and gnt outputs take IDLE values, and all rdy, acc_fault and to_err outputs = 0.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the master not equal to last-owner wins; last-owner updates on every GNTx entry.
REQ-035 Without ARB_ROUND_ROBIN_EN: m0 always wins simultaneous requests, and the last-owner register is not implemented.

Verification
REQ-036 m0 read to ROM only; s_rdy = 1 two cycles after grant -> gnt = 01; m0_rdy = 1 in the same cycle; IDLE for 1 cycle; gnt = 00.
REQ-037 m0 and m1 both request continuously, ARB_ROUND_ROBIN_EN defined -> grants alternate m0, m1, m0, m1, with 1 IDLE cycle between each.
REQ-038 Same stimulus as REQ-037 without the macro -> m0 granted every time; m1 never granted while m0 requests.
REQ-039 TIMEOUT = 4; m1 write; s_rdy held 0 -> FAULT on the 5th cycle after grant; m1_acc_fault = 1 and to_err = 1 for one cycle; s_wr_n = 1 in that cycle.
REQ-040 rst asserted in GNT1 mid-transfer -> from the next cycle gnt = 00, s_rd_n = s_wr_n = 1, and m1 rdy/acc_fault = 0; the first grant after reset goes to m0 on simultaneous requests.
REQ-041 s_acc_fault = 1 on the same cycle the counter expires -> m0_acc_fault passes through; no FAULT state; to_err = 0.
